// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide on operand magnitudes, one iteration per clock, with signs fixed up at the end.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic [4:0]      dest_in,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result,
  output logic [4:0]      dest_out
);
  localparam int CW = $clog2(XLEN);
  localparam logic [1:0] S_IDLE = 2'd0, S_CALC = 2'd1, S_DONE = 2'd2;

  logic [1:0]      state;
  logic [CW-1:0]   count;
  logic [XLEN-1:0] hi, lo, dvs;
  logic [XLEN-1:0] hi_n, lo_n;
  logic [2:0]      op_q;
  logic            neg_q, neg_r;
  logic [4:0]      dest_q;

  logic            is_div, sgn_a, sgn_b, a_neg, b_neg;
  logic            div_zero, div_ovf, special, accept;
  logic [XLEN-1:0] a_mag, b_mag, spec_res, fin;

  // Request decode, evaluated on the live inputs and used only at the accepting edge.
  always_comb begin
    is_div   = funct3[2];
    sgn_a    = is_div ? ~funct3[0] : (funct3[1:0] == 2'd1 || funct3[1:0] == 2'd2);
    sgn_b    = is_div ? ~funct3[0] : (funct3[1:0] == 2'd1);
    a_neg    = sgn_a & op_a[XLEN-1];
    b_neg    = sgn_b & op_b[XLEN-1];
    a_mag    = a_neg ? -op_a : op_a;
    b_mag    = b_neg ? -op_b : op_b;
    div_zero = is_div && (op_b == '0);
    div_ovf  = is_div && ~funct3[0] && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special  = div_zero | div_ovf;
    if (div_zero) spec_res = funct3[1] ? op_a : '1;
    else          spec_res = funct3[1] ? '0 : op_a;
    accept   = start && !flush && (state == S_IDLE || state == S_DONE);
  end

  // One iteration. Multiply: {hi,lo} holds {partial sum, remaining multiplier}.
  // Divide: hi is the partial remainder, lo shifts dividend out and quotient in.
  logic [XLEN:0] sum, sh;
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, dvs} : '0);
    sh  = {hi, lo[XLEN-1]};
    if (op_q[2]) begin
      if (sh >= {1'b0, dvs}) begin
        hi_n = XLEN'(sh - {1'b0, dvs});
        lo_n = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_n = sh[XLEN-1:0];
        lo_n = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      hi_n = sum[XLEN:1];
      lo_n = {sum[0], lo[XLEN-1:1]};
    end
  end

  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  always_comb begin
    prod = {hi_n, lo_n};
    if (neg_q) prod = -prod;
    quo = neg_q ? -lo_n : lo_n;
    rem = neg_r ? -hi_n : hi_n;
    case (op_q)
      3'd0:             fin = prod[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin = prod[2*XLEN-1:XLEN];
      3'd4, 3'd5:       fin = quo;
      default:          fin = rem;
    endcase
  end

  // dest_out moves together with result so an aborted op leaves both untouched.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_IDLE;
      count    <= '0;
      hi       <= '0;
      lo       <= '0;
      dvs      <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      dest_q   <= '0;
      result   <= '0;
      dest_out <= '0;
    end else if (flush) begin
      state <= S_IDLE;
      count <= '0;
    end else if (accept) begin
      op_q   <= funct3;
      neg_q  <= a_neg ^ b_neg;
      neg_r  <= a_neg;
      dest_q <= dest_in;
      hi     <= '0;
      lo     <= a_mag;
      dvs    <= b_mag;
      count  <= '0;
      if (special) begin
        result   <= spec_res;
        dest_out <= dest_in;
        state    <= S_DONE;
      end else begin
        state <= S_CALC;
      end
    end else if (state == S_CALC) begin
      hi    <= hi_n;
      lo    <= lo_n;
      count <= count + 1'b1;
      if (count == CW'(XLEN-1)) begin
        result   <= fin;
        dest_out <= dest_q;
        state    <= S_DONE;
      end
    end else if (state == S_DONE) begin
      state <= S_IDLE;
    end
  end

  assign busy = (state == S_CALC);
  assign done = (state == S_DONE);

endmodule

// File: tb/tb_muldiv_unit.sv
// Randomized bench for muldiv_unit against a plain 64-bit arithmetic reference.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        rst, start, flush;
  logic [2:0]  funct3;
  logic [31:0] op_a, op_b;
  logic [4:0]  dest_in;
  logic        busy, done;
  logic [31:0] result;
  logic [4:0]  dest_out;

  int n_chk = 0, n_err = 0;
  logic [31:0] prev_res;
  logic [4:0]  prev_dst;

  muldiv_unit #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .start(start), .flush(flush), .funct3(funct3),
    .op_a(op_a), .op_b(op_b), .dest_in(dest_in),
    .busy(busy), .done(done), .result(result), .dest_out(dest_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  always @(negedge clk) if (rst) check("busy_done_excl", {63'd0, busy & done}, 64'd0);

  function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, ua, ub;
    logic [63:0] p;
    logic signed [31:0] a32, b32;
    logic ovf;
    sa = longint'($signed(a)); sb = longint'($signed(b));
    ua = longint'({32'h0, a}); ub = longint'({32'h0, b});
    a32 = a; b32 = b;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    case (f)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(a32 / b32);
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: return (b == 0) ? a : ovf ? 32'h0 : 32'(a32 % b32);
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int lat_of(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    if (f[2] && b == 0) return 1;
    if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  // Present one request, scramble the inputs right after acceptance, wait for done.
  task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] d, input logic [31:0] exp, input int lat);
    int n;
    start = 1'b1; funct3 = f; op_a = a; op_b = b; dest_in = d;
    @(posedge clk); #1;
    start = 1'b0; funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; dest_in = 5'($urandom);
    n = 1;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check("latency", 64'(n), 64'(lat));
    check("result", {32'd0, result}, {32'd0, exp});
    check("dest_out", {59'd0, dest_out}, {59'd0, d});
    check("busy_at_done", {63'd0, busy}, 64'd0);
    prev_res = exp; prev_dst = d;
  endtask

  task automatic idle_chk(input int k);
    repeat (k) begin
      @(posedge clk); #1;
      check("no_done", {63'd0, done}, 64'd0);
      check("no_busy", {63'd0, busy}, 64'd0);
    end
  endtask

  task automatic rand_op(output logic [2:0] f, output logic [31:0] a, output logic [31:0] b);
    int m;
    f = 3'($urandom_range(7));
    a = $urandom; b = $urandom;
    m = $urandom_range(9);
    case (m)
      0: b = 32'h0;
      1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      2: begin a = 32'($urandom_range(300)) - 32'd150; b = 32'($urandom_range(40)) - 32'd20; end
      3: begin a = 32'hFFFF_FFFF; b = $urandom_range(3); end
      default: ;
    endcase
  endtask

  typedef struct { logic [2:0] f; logic [31:0] a, b, exp; int lat; } vec_t;
  vec_t vecs[11];

  initial begin
    logic [2:0] f; logic [31:0] a, b; logic [4:0] d; int n;
    rst = 1'b0; start = 1'b0; flush = 1'b0; funct3 = '0; op_a = '0; op_b = '0; dest_in = '0;
    prev_res = '0; prev_dst = '0;
    repeat (3) @(posedge clk); #1;
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_result", {32'd0, result}, 64'd0);
    check("rst_dest", {59'd0, dest_out}, 64'd0);
    rst = 1'b1;
    @(posedge clk); #1;

    vecs[0]  = '{3'd0, 32'h7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vecs[1]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vecs[2]  = '{3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         33};
    vecs[3]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 33};
    vecs[4]  = '{3'd4, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFD, 33};
    vecs[5]  = '{3'd6, 32'hFFFF_FFF9,  32'h2,         32'hFFFF_FFFF, 33};
    vecs[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        33};
    vecs[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         33};
    vecs[8]  = '{3'd5, 32'h1234,       32'h0,         32'hFFFF_FFFF, 1};
    vecs[9]  = '{3'd7, 32'h1234,       32'h0,         32'h1234,      1};
    vecs[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1};
    foreach (vecs[i]) begin
      run_op(vecs[i].f, vecs[i].a, vecs[i].b, 5'(i + 5), vecs[i].exp, vecs[i].lat);
      if (i % 2 == 1) idle_chk(1);
    end

    // start held through CALC: the second op is taken only in the DONE cycle
    idle_chk(1);
    start = 1'b1; funct3 = 3'd0; op_a = 32'h7; op_b = 32'hFFFF_FFFD; dest_in = 5'd5;
    @(posedge clk); #1;
    funct3 = 3'd5; op_a = 32'd100; op_b = 32'd7; dest_in = 5'd9;
    n = 1;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check("hold_lat1", 64'(n), 64'd33);
    check("hold_res1", {32'd0, result}, 64'hFFFF_FFEB);
    check("hold_dst1", {59'd0, dest_out}, 64'd5);
    @(posedge clk); #1;
    start = 1'b0;
    n = 1;
    while (!done && n < 40) begin @(posedge clk); #1; n++; end
    check("hold_lat2", 64'(n), 64'd33);
    check("hold_res2", {32'd0, result}, 64'd14);
    check("hold_dst2", {59'd0, dest_out}, 64'd9);
    prev_res = 32'd14; prev_dst = 5'd9;
    idle_chk(1);

    // flush at iteration 10
    start = 1'b1; funct3 = 3'd3; op_a = $urandom; op_b = $urandom; dest_in = 5'd17;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk); #1;
    check("flush_busy_before", {63'd0, busy}, 64'd1);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {63'd0, busy}, 64'd0);
    check("flush_done", {63'd0, done}, 64'd0);
    check("flush_res_hold", {32'd0, result}, {32'd0, prev_res});
    check("flush_dst_hold", {59'd0, dest_out}, {59'd0, prev_dst});
    idle_chk(40);
    run_op(3'd4, 32'hFFFF_FF00, 32'd3, 5'd12, model(3'd4, 32'hFFFF_FF00, 32'd3), 33);

    // flush beats start in the DONE cycle
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd4; dest_in = 5'd1;
    @(posedge clk); #1;
    start = 1'b0; flush = 1'b0;
    check("flush_start_busy", {63'd0, busy}, 64'd0);
    idle_chk(40);
    check("flush_start_res", {32'd0, result}, {32'd0, prev_res});

    // async reset at iteration 10
    start = 1'b1; funct3 = 3'd6; op_a = $urandom; op_b = 32'd13; dest_in = 5'd22;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check("arst_busy", {63'd0, busy}, 64'd0);
    check("arst_done", {63'd0, done}, 64'd0);
    check("arst_result", {32'd0, result}, 64'd0);
    check("arst_dest", {59'd0, dest_out}, 64'd0);
    @(posedge clk); #1;
    rst = 1'b1;
    idle_chk(40);
    run_op(3'd1, 32'h8000_0000, 32'h8000_0000, 5'd30, model(3'd1, 32'h8000_0000, 32'h8000_0000), 33);

    // randomized traffic, mixing back-to-back and idle gaps
    for (int k = 0; k < 200; k++) begin
      rand_op(f, a, b);
      d = 5'($urandom);
      run_op(f, a, b, d, model(f, a, b), lat_of(f, a, b));
      if ($urandom_range(1) == 1) idle_chk($urandom_range(1, 3));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
